// File: rtl/uart_arb_pkg.sv
// Shared state encoding, trailer characters and round-robin pick for uart_tx_arbiter.
// The CR/LF trailer states exist only when UART_ARB_CRLF_EN is defined.
package uart_arb_pkg;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam int         MAX_REQ = 8;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    LOAD    = 4'd2,
    WAIT_HI = 4'd3,
    WAIT_LO = 4'd4
`ifdef UART_ARB_CRLF_EN
    , CR_LOAD = 4'd5,
    CR_WAIT = 4'd6,
    LF_LOAD = 4'd7,
    LF_WAIT = 4'd8
`endif
  } arb_state_e;

  // First set request at or after ptr, wrapping modulo n; scanned from the far
  // end so the smallest offset is the last (winning) assignment.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [2:0] ptr, input int n);
    logic [MAX_REQ-1:0] g;
    logic [2:0]         idx;
    g = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      idx = 3'((int'(ptr) + i) % n);
      if (i < n && req[idx]) g = 8'b1 << idx;
    end
    return g;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side stream bus plus the uart_tx send handshake seen by the arbiter.
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 2);
  logic [NUM_REQ-1:0]      req, req_valid, req_last, req_ready, grant;
  logic [NUM_REQ-1:0][7:0] req_data;
  logic                    tx_en, tx_busy, arb_busy;
  logic [7:0]              tx_data;

  modport master (input  req, req_data, req_valid, req_last, tx_busy,
                  output req_ready, grant, tx_en, tx_data, arb_busy);
  modport slave  (output req, req_data, req_valid, req_last, tx_busy,
                  input  req_ready, grant, tx_en, tx_data, arb_busy);
endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick with a registered pointer that moves past the
// owner when it releases.
module uart_rr_arbiter
  import uart_arb_pkg::*;
#(parameter int NUM_REQ = 2) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv,
  input  logic [NUM_REQ-1:0] owner,
  output logic [NUM_REQ-1:0] pick
);
  logic [2:0]         ptr;
  logic [2:0]         owner_idx;
  logic [MAX_REQ-1:0] req_w, pick_w;
  logic               unused_pick_hi;

  always_comb begin
    req_w = '0;
    req_w[NUM_REQ-1:0] = req;
    pick_w = rr_pick(req_w, ptr, NUM_REQ);
    owner_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (owner[i]) owner_idx = 3'(i);
  end

  assign pick           = pick_w[NUM_REQ-1:0];
  assign unused_pick_hi = ^pick_w;

  always_ff @(posedge clk) begin
    if (rst)      ptr <= '0;
    else if (adv) ptr <= (owner_idx == 3'(NUM_REQ - 1)) ? 3'd0 : owner_idx + 3'd1;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ message streams; grant is held for a whole message.
// Define UART_ARB_CRLF_EN to append CR LF after every message.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.master  bus
);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  arb_state_e         state;
  logic [NUM_REQ-1:0] grant, pick;
  logic [7:0]         tx_data, sel_data;
  logic               last_seen, sel_last, accept;
  logic               in_hi, in_lo, timeout, byte_done, msg_done;
  logic [CW-1:0]      wcnt;
`ifdef UART_ARB_CRLF_EN
  logic               hi_seen;
`endif

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk(clk), .rst(rst), .req(bus.req), .adv(msg_done), .owner(grant), .pick(pick)
  );

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) begin
        sel_data = bus.req_data[i];
        sel_last = bus.req_last[i];
      end
  end

  assign accept  = (state == FETCH) && |(grant & bus.req_valid);
  assign timeout = (wcnt == CW'(BUSY_TIMEOUT - 1));

  // Trailer bytes share one wait state each; hi_seen splits it into the
  // busy-rise and busy-fall phases.
`ifdef UART_ARB_CRLF_EN
  assign in_hi     = (state == WAIT_HI) || ((state == CR_WAIT || state == LF_WAIT) && !hi_seen);
  assign in_lo     = (state == WAIT_LO) || ((state == CR_WAIT || state == LF_WAIT) && hi_seen);
  assign bus.tx_en = (state == LOAD) || (state == CR_LOAD) || (state == LF_LOAD);
  assign msg_done  = (state == LF_WAIT) && byte_done;
`else
  assign in_hi     = (state == WAIT_HI);
  assign in_lo     = (state == WAIT_LO);
  assign bus.tx_en = (state == LOAD);
  assign msg_done  = (state == WAIT_HI || state == WAIT_LO) && byte_done && last_seen;
`endif

  // A stuck busy handshake ends the byte after BUSY_TIMEOUT cycles of waiting.
  assign byte_done     = !bus.tx_busy && ((in_hi && timeout) || in_lo);
  assign bus.req_ready = (state == FETCH) ? (grant & bus.req_valid) : '0;
  assign bus.grant     = grant;
  assign bus.tx_data   = tx_data;
  assign bus.arb_busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      tx_data   <= '0;
      last_seen <= 1'b0;
      wcnt      <= '0;
`ifdef UART_ARB_CRLF_EN
      hi_seen   <= 1'b0;
`endif
    end else begin
      wcnt <= in_hi ? wcnt + CW'(1) : '0;
      case (state)
        IDLE: if (|bus.req) begin
          grant <= pick;
          state <= FETCH;
        end
        FETCH: if (accept) begin
          tx_data   <= sel_data;
          last_seen <= sel_last;
          state     <= LOAD;
        end
        LOAD: state <= WAIT_HI;
        WAIT_HI, WAIT_LO: begin
          if (state == WAIT_HI && bus.tx_busy) state <= WAIT_LO;
          if (byte_done) begin
            if (!last_seen) state <= FETCH;
            else begin
`ifdef UART_ARB_CRLF_EN
              state   <= CR_LOAD;
              tx_data <= CHAR_CR;
`else
              state <= IDLE;
              grant <= '0;
`endif
            end
          end
        end
`ifdef UART_ARB_CRLF_EN
        CR_LOAD, LF_LOAD: begin
          state   <= (state == CR_LOAD) ? CR_WAIT : LF_WAIT;
          hi_seen <= 1'b0;
        end
        CR_WAIT, LF_WAIT: begin
          if (bus.tx_busy) hi_seen <= 1'b1;
          if (byte_done) begin
            if (state == CR_WAIT) begin
              state   <= LF_LOAD;
              tx_data <= CHAR_LF;
            end else begin
              state <= IDLE;
              grant <= '0;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-driven sources, a busy-holding uart_tx
// model and a log of every byte presented on tx_en.
module tb_uart_tx_arbiter;
  localparam int NR = 2;
`ifdef UART_ARB_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();
  uart_tx_arbiter #(.NUM_REQ(NR), .BUSY_TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  int         pass_cnt = 0, fail_cnt = 0, total = 0;
  logic [8:0] q0[$], q1[$];
  logic [9:0] txlog[$], expq[$];
  logic [1:0] gap = '0, drop = '0;
  logic       acc0 = 1'b0, acc1 = 1'b0, stuck = 1'b0, en_n = 1'b0;
  int         bcnt = 0;

  // uart_tx model: busy for 10 cycles after an accepted send, or never when stuck.
  assign bus.tx_busy = (bcnt != 0);
  always @(negedge clk) begin
    en_n <= bus.tx_en & ~bus.tx_busy;
    if (!rst && bus.tx_en) txlog.push_back({bus.grant, bus.tx_data});
  end
  always @(posedge clk) begin
    if (rst)                 bcnt <= 0;
    else if (en_n && !stuck) bcnt <= 10;
    else if (bcnt > 0)       bcnt <= bcnt - 1;
  end

  // Sources: pop on the handshake seen last cycle, then present the queue head.
  initial begin
    bus.req = '0; bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0;
    forever begin
      @(negedge clk);
      if (acc0 && q0.size() != 0) void'(q0.pop_front());
      if (acc1 && q1.size() != 0) void'(q1.pop_front());
      #2;
      bus.req[0]       = q0.size() != 0 && !drop[0];
      bus.req_valid[0] = q0.size() != 0 && !gap[0];
      bus.req_data[0]  = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
      bus.req_last[0]  = (q0.size() != 0) ? q0[0][8] : 1'b0;
      bus.req[1]       = q1.size() != 0 && !drop[1];
      bus.req_valid[1] = q1.size() != 0 && !gap[1];
      bus.req_data[1]  = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
      bus.req_last[1]  = (q1.size() != 0) ? q1[0][8] : 1'b0;
      #1;
      acc0 = bus.req_ready[0] && !rst;
      acc1 = bus.req_ready[1] && !rst;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  task automatic src(input int s, input logic [7:0] d, input logic l);
    if (s == 0) q0.push_back({l, d});
    else        q1.push_back({l, d});
  endtask

  task automatic expb(input int s, input logic [7:0] d, input logic l);
    logic [1:0] g;
    g = (s == 0) ? 2'b01 : 2'b10;
    expq.push_back({g, d});
    if (l && CRLF) begin
      expq.push_back({g, 8'h0D});
      expq.push_back({g, 8'h0A});
    end
  endtask

  task automatic msg(input int s, input logic [7:0] d, input logic l);
    src(s, d, l);
    expb(s, d, l);
  endtask

  task automatic cmp_log(input string tag);
    check({tag, "_len"}, 32'(txlog.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < txlog.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 32'(txlog[i]), 32'(expq[i]));
    txlog.delete();
    expq.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((bus.arb_busy || q0.size() != 0 || q1.size() != 0) && n < 800) begin
      step();
      n++;
    end
    check({tag, "_idle"}, 32'(n < 800), 32'd1);
  endtask

  task automatic wait_log(input int cnt, input string tag);
    int n = 0;
    while (txlog.size() < cnt && n < 200) begin
      step();
      n++;
    end
    check({tag, "_log_wait"}, 32'(n < 200), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) step();
    check("rst_grant",    32'(bus.grant),     32'd0);
    check("rst_ready",    32'(bus.req_ready), 32'd0);
    check("rst_tx_en",    32'(bus.tx_en),     32'd0);
    check("rst_tx_data",  32'(bus.tx_data),   32'd0);
    check("rst_arb_busy", 32'(bus.arb_busy),  32'd0);
    check("rst_ptr",      32'(dut.u_rr.ptr),  32'd0);
    rst = 1'b0;
    step();

    // Single source, three bytes, including first-byte latency.
    msg(0, 8'h43, 1'b0); msg(0, 8'h6F, 1'b0); msg(0, 8'h64, 1'b1);
    step();
    check("t1_grant",  32'(bus.grant),    32'h1);
    check("t1_en_c1",  32'(bus.tx_en),    32'd0);
    check("t1_busy",   32'(bus.arb_busy), 32'd1);
    step();
    check("t1_en_c2",  32'(bus.tx_en),    32'd1);
    check("t1_data",   32'(bus.tx_data),  32'h43);
    wait_idle("t1");
    check("t1_grant_end", 32'(bus.grant), 32'd0);
    cmp_log("t1");

    // Contention straight out of reset.
    rst = 1'b1; step(); rst = 1'b0;
    check("t2_ptr_rst", 32'(dut.u_rr.ptr), 32'd0);
    msg(0, 8'hA0, 1'b0); msg(0, 8'hA1, 1'b1);
    msg(1, 8'hB0, 1'b0); msg(1, 8'hB1, 1'b1);
    wait_idle("t2");
    cmp_log("t2");
    check("t2_ptr", 32'(dut.u_rr.ptr), 32'd0);

    // Fairness: src0 has back-to-back messages, src1 arrives during the first.
    src(0, 8'hC0, 1'b0); src(0, 8'hC1, 1'b1); src(0, 8'hD0, 1'b0); src(0, 8'hD1, 1'b1);
    wait_log(1, "t3");
    src(1, 8'hE0, 1'b1);
    expb(0, 8'hC0, 1'b0); expb(0, 8'hC1, 1'b1); expb(1, 8'hE0, 1'b1);
    expb(0, 8'hD0, 1'b0); expb(0, 8'hD1, 1'b1);
    wait_idle("t3");
    cmp_log("t3");

    // Valid gap of 20 cycles with req dropped before last.
    msg(1, 8'hF0, 1'b0); msg(1, 8'hF1, 1'b0); msg(1, 8'hF2, 1'b1);
    wait_log(1, "t4");
    gap[1] = 1'b1; drop[1] = 1'b1;
    repeat (20) step();
    check("t4_gap_log",   32'(txlog.size()),  32'd1);
    check("t4_gap_grant", 32'(bus.grant),     32'h2);
    check("t4_gap_busy",  32'(bus.arb_busy),  32'd1);
    gap[1] = 1'b0;
    wait_idle("t4");
    drop[1] = 1'b0;
    cmp_log("t4");

    // Busy never rises: LOAD + 16 WAIT_HI + FETCH, next tx_en 18 cycles later.
    stuck = 1'b1;
    msg(0, 8'h47, 1'b0); msg(0, 8'h67, 1'b1);
    wait_log(1, "t5");
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.tx_en && n < 40);
    check("t5_timeout_gap", 32'(n), 32'd18);
    wait_idle("t5");
    cmp_log("t5");
    stuck = 1'b0;

    // Reset mid-message.
    src(1, 8'h48, 1'b0); src(1, 8'h49, 1'b1);
    wait_log(1, "t6");
    step(); step();
    rst = 1'b1;
    step();
    check("t6_grant",    32'(bus.grant),     32'd0);
    check("t6_ready",    32'(bus.req_ready), 32'd0);
    check("t6_tx_en",    32'(bus.tx_en),     32'd0);
    check("t6_tx_data",  32'(bus.tx_data),   32'd0);
    check("t6_arb_busy", 32'(bus.arb_busy),  32'd0);
    check("t6_ptr",      32'(dut.u_rr.ptr),  32'd0);
    q0.delete(); q1.delete(); txlog.delete();
    rst = 1'b0;
    step();

    // One-byte message; CR LF follow when the trailer is built in.
    msg(0, 8'h41, 1'b1);
    wait_idle("t7");
    cmp_log("t7");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
